// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: bus bundle between the execute stage, the LSU and the
// word-organised data memory.
//   slave  modport: LSU view (takes requests, returns responses, drives memory).
//   master modport: environment view (issues requests, models data_mem).
// Signals:
//   req_valid/req_ready   request handshake (accept when both high)
//   req_we/size/unsigned  store flag, 00 byte / 01 half / 10 word / 11 reserved,
//                         zero-extend flag for loads
//   req_addr/req_wdata    byte address, right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata/resp_err   extended load data / misaligned-reserved flag
//   mem_addr/mem_wdata/mem_we/mem_rdata  word port of data_mem (comb read)
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit in front of a word-wide
// data memory with combinational read and clocked write. Byte/halfword
// loads are extracted and sign/zero-extended; byte/halfword stores are done
// as read-modify-write (read old word, merge lane, write back).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  lsu_mem_ctrl_if.slave (request, response and memory port)
// Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned
// halfword/word requests and req_size=11 into an error response with no
// memory access. Without it low address bits below the access size are
// ignored and req_size=11 behaves as a word access.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  lsu_mem_ctrl_if.slave   bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, STORE, RESP
  } state_t;

  state_t                          state_q, state_d;
  logic                            we_q, uns_q, err_q;
  logic [1:0]                      size_q;
  logic [ADDR_W-1:0]               addr_q;
  logic [31:0]                     wdata_q, rdata_q;
  logic [NUM_LANES-1:0][7:0]       old_q;
  logic                            accept, req_err;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Request classification at the accept edge.
`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end
`else
  always_comb req_err = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (req_err)           state_d = RESP;
        else if (!bus.req_we)  state_d = LOAD;
        else if (bus.req_size[1]) state_d = STORE;   // 10 and (untrapped) 11
        else                   state_d = RMW_RD;
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = STORE;
      STORE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- load extract
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  always_comb begin
    ld_b   = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_h   = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  // ------------------------------------------------------------ store merge
  // Store data is replicated across all lanes; the byte enables pick which
  // lanes take it and which keep the word read during RMW_RD.
  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0][7:0]       wrep, merged;

  always_comb begin
    case (size_q)
      2'b00: begin
        be   = 4'b0001 << addr_q[1:0];
        wrep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_q[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata_q;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[i] = be[i] ? wrep[i] : old_q[i];
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;              // stores and errors return 0
      end
      if (state_q == LOAD)   rdata_q <= ld_ext;
      if (state_q == RMW_RD) old_q   <= bus.mem_rdata;
    end
  end

  // --------------------------------------------------------------- outputs
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_we     = (state_q == STORE);
  assign bus.mem_wdata  = (state_q == STORE) ? merged : 32'h0;

  // we_q is kept for debug visibility of the captured request.
  logic unused_ok;
  assign unused_ok = we_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed test-plan sequences plus randomized requests,
// checked against a word-array reference model with arithmetic lane rules.
module tb_lsu_mem_ctrl;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus();
  lsu_mem_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // data_mem stand-in: 64 words, combinational read, clocked write
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  function automatic bit m_err(input int size, input int a);
    if (!TRAP) return 1'b0;
    return (size == 3) || (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input int size,
                                          input bit uns, input int a);
    logic [31:0] v;
    if (size == 0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (size == 1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input int size,
                                           input logic [31:0] wd, input int a);
    int sh;
    if (size == 0) begin
      sh = 8 * (a % 4);
      return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (size == 1) begin
      sh = 16 * ((a / 2) % 2);
      return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  // --------------------------------------------------------- transaction
  task automatic xact(input bit we, input int size, input bit uns, input int a,
                      input logic [31:0] wd, input string tag, output logic [31:0] rd);
    int wi, t, exp_resp, exp_we_c, resp_c, resp_n, we_n, we_c, busy_bad, idle_bad;
    bit e;
    logic [31:0] exp_rd;
    wi = (a / 4) % 64;
    e  = m_err(size, a);
    exp_rd = 32'h0;
    if (e)                 begin exp_resp = 1; exp_we_c = 0; end
    else if (!we)          begin exp_resp = 2; exp_we_c = 0; exp_rd = m_load(ref_mem[wi], size, uns, a); end
    else if (size >= 2)    begin exp_resp = 2; exp_we_c = 1; end
    else                   begin exp_resp = 3; exp_we_c = 2; end
    if (we && !e) ref_mem[wi] = m_store(ref_mem[wi], size, wd, a);

    @(negedge clk);
    t = 0;
    while (!bus.req_ready && t < 10) begin @(negedge clk); t++; end
    chk({tag, " ready"}, 32'(bus.req_ready), 32'h1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = 2'(size);
    bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    // scramble inputs: the unit must work from its captured copy
    bus.req_valid = 1'b0; bus.req_we = $urandom; bus.req_size = 2'($urandom);
    bus.req_unsigned = $urandom; bus.req_addr = $urandom; bus.req_wdata = $urandom;

    resp_c = 0; resp_n = 0; we_n = 0; we_c = 0; busy_bad = 0; idle_bad = 0; rd = 32'hX;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        resp_n++;
        if (resp_c == 0) begin
          resp_c = c; rd = bus.resp_rdata;
          chk({tag, " err"}, 32'(bus.resp_err), 32'(e));
        end
      end else if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) idle_bad++;
      if (bus.mem_we) begin we_n++; we_c = c; end
      if (c <= exp_resp && bus.req_ready) busy_bad++;
    end
    chk({tag, " resp_cycle"}, resp_c, exp_resp);
    chk({tag, " resp_pulses"}, resp_n, 1);
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " we_count"}, we_n, (exp_we_c != 0) ? 1 : 0);
    chk({tag, " we_cycle"}, we_c, exp_we_c);
    chk({tag, " ready_low"}, busy_bad, 0);
    chk({tag, " idle_zero"}, idle_bad, 0);
    chk({tag, " mem_word"}, mem[wi], ref_mem[wi]);
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    logic [31:0] rd, exp_w;
    int acc, rsp, bad;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_w;
    int acc, rsp, bad;
    for (int i = 0; i < 64; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst resp_err", 32'(bus.resp_err), 32'h0);
    chk("rst mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;

    // word store / load
    xact(1, 2, 0, 'h10, 32'hDEADBEEF, "sw10", rd);
    chk("tp1 mem4", mem[4], 32'hDEADBEEF);
    xact(0, 2, 0, 'h10, 32'h0, "lw10", rd);
    chk("tp1 lw", rd, 32'hDEADBEEF);

    // byte store over 0x11223344
    xact(1, 2, 0, 'h10, 32'h11223344, "sw10b", rd);
    xact(1, 0, 0, 'h13, 32'h00000080, "sb13", rd);
    chk("tp2 mem4", mem[4], 32'h80223344);
    xact(0, 0, 0, 'h13, 32'h0, "lb13", rd);
    chk("tp2 lb", rd, 32'hFFFFFF80);
    xact(0, 0, 1, 'h13, 32'h0, "lbu13", rd);
    chk("tp2 lbu", rd, 32'h00000080);

    // halfword store over zeros
    xact(1, 1, 0, 'h22, 32'h0000A5A5, "sh22", rd);
    xact(0, 1, 0, 'h22, 32'h0, "lh22", rd);
    chk("tp3 lh22", rd, 32'hFFFFA5A5);
    xact(0, 1, 1, 'h22, 32'h0, "lhu22", rd);
    chk("tp3 lhu22", rd, 32'h0000A5A5);
    xact(0, 1, 0, 'h20, 32'h0, "lh20", rd);
    chk("tp3 lh20", rd, 32'h00000000);

    // misaligned word store
    xact(1, 2, 0, 'h06, 32'hCAFEF00D, "sw06", rd);
    chk("tp5 mem1", mem[1], TRAP ? 32'h0 : 32'hCAFEF00D);

    // back-to-back loads with req_valid held
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    exp_w = ref_mem[4];
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    acc = 0; rsp = 0; bad = 0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.req_ready) acc++;
      if (bus.req_ready !== (k % 3 == 0)) bad++;
      if (bus.resp_valid) begin rsp++; chk("b2b rdata", bus.resp_rdata, exp_w); end
    end
    bus.req_valid = 1'b0;
    chk("b2b accepts", acc, 3);
    chk("b2b resps", rsp, 3);
    chk("b2b ready_pattern", bad, 0);

    // reset while a load sits in LOAD
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstmid c1 resp_valid", 32'(bus.resp_valid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid req_ready", 32'(bus.req_ready), 32'h1);
    chk("rstmid resp_rdata", bus.resp_rdata, 32'h0);
    chk("rstmid mem_we", 32'(bus.mem_we), 32'h0);
    chk("rstmid mem_addr", bus.mem_addr, 32'h0);
    chk("rstmid mem_wdata", bus.mem_wdata, 32'h0);
    rsp = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid) rsp++;
      @(negedge clk);
    end
    chk("rstmid no_resp", rsp, 0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int sz, ad;
      bit w, u;
      w  = 1'($urandom);
      sz = $urandom_range(0, 3);
      u  = 1'($urandom);
      ad = $urandom_range(0, 255);
      xact(w, sz, u, ad, $urandom, $sformatf("rnd%0d", n), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
